// File: rtl/blur_scale_sched_pkg.sv
// ---------------------------------------------------------------------------
// blur_sched_pkg
// Shared types and helpers for the blur scale-space scheduler.
//   state_t    : scheduler FSM states
//   num_banks  : number of image banks in one octave (source + one per pass)
// ---------------------------------------------------------------------------
package blur_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int num_banks(input int num_scales);
        return num_scales + 1;
    endfunction

endpackage

// File: rtl/blur_scale_sched_if.sv
// ---------------------------------------------------------------------------
// blur_scale_sched_if
// Groups the blur-engine handshake/data path and the shared bank BRAM bus.
// Parameters: BIT_DEPTH (pixel width), AW (pixel address width), NB (banks).
// Modports:
//   master : the scheduler (drives engine start/read data and bank controls)
//   slave  : the environment (engine + banks)
// ---------------------------------------------------------------------------
interface blur_scale_sched_if #(
    parameter int BIT_DEPTH = 8,
    parameter int AW        = 12,
    parameter int NB        = 6
);
    // Engine side
    logic                    blur_start_out;
    logic                    blur_done_in;
    logic [AW-1:0]           blur_rd_addr_in;
    logic [BIT_DEPTH-1:0]    blur_pixel_out;
    logic [AW-1:0]           blur_wr_addr_in;
    logic                    blur_wr_valid_in;
    logic [BIT_DEPTH-1:0]    blur_wr_pixel_in;
    // Bank side
    logic [AW-1:0]           bank_rd_addr_out;
    logic [NB*BIT_DEPTH-1:0] bank_rd_data_in;
    logic [AW-1:0]           bank_wr_addr_out;
    logic [BIT_DEPTH-1:0]    bank_wr_data_out;
    logic [NB-1:0]           bank_wr_en_out;

    modport master (
        output blur_start_out, blur_pixel_out,
               bank_rd_addr_out, bank_wr_addr_out, bank_wr_data_out, bank_wr_en_out,
        input  blur_done_in, blur_rd_addr_in, blur_wr_addr_in, blur_wr_valid_in,
               blur_wr_pixel_in, bank_rd_data_in
    );

    modport slave (
        input  blur_start_out, blur_pixel_out,
               bank_rd_addr_out, bank_wr_addr_out, bank_wr_data_out, bank_wr_en_out,
        output blur_done_in, blur_rd_addr_in, blur_wr_addr_in, blur_wr_valid_in,
               blur_wr_pixel_in, bank_rd_data_in
    );

endinterface

// File: rtl/blur_scale_sched_bank_router.sv
// ---------------------------------------------------------------------------
// bank_router
// Combinational bank steering for the blur scheduler.
//   rd_sel_i   : bank whose read data feeds the engine
//   wr_sel_i   : bank that receives engine writes
//   wr_allow_i : write window open (scheduler in START/RUN)
//   wr_valid_i : engine write strobe
//   rd_data_i  : packed bank read data, bank b at [b*BIT_DEPTH +: BIT_DEPTH]
//   rd_pixel_o : selected read pixel
//   wr_en_o    : one-hot bank write enable
// ---------------------------------------------------------------------------
module bank_router #(
    parameter int BIT_DEPTH = 8,
    parameter int NB        = 6,
    parameter int SW        = 3
) (
    input  logic [SW-1:0]           rd_sel_i,
    input  logic [SW-1:0]           wr_sel_i,
    input  logic                    wr_allow_i,
    input  logic                    wr_valid_i,
    input  logic [NB*BIT_DEPTH-1:0] rd_data_i,
    output logic [BIT_DEPTH-1:0]    rd_pixel_o,
    output logic [NB-1:0]           wr_en_o
);

    always_comb begin
        rd_pixel_o = '0;
        wr_en_o    = '0;
        for (int b = 0; b < NB; b++) begin
            if (rd_sel_i == SW'(b)) begin
                rd_pixel_o = rd_data_i[b*BIT_DEPTH +: BIT_DEPTH];
            end
            if (wr_sel_i == SW'(b)) begin
                wr_en_o[b] = wr_allow_i & wr_valid_i;
            end
        end
    end

endmodule

// File: rtl/blur_scale_sched.sv
// ---------------------------------------------------------------------------
// blur_scale_sched
// Runs the blur engine NUM_SCALES times to build one scale-space octave.
// Pass k reads bank k and writes bank k+1; bank 0 holds the source image.
// Optional watchdog: define BLUR_TIMEOUT_EN to abort a pass that runs for
// TIMEOUT cycles without an engine done (sets sticky error_out).
// Ports:
//   clk_in, rst_in (async, active-low)
//   start_in        : begin an octave (ignored while busy)
//   busy_out        : octave in progress (through the done_out cycle)
//   done_out        : all passes finished (1-cycle)
//   scale_done_out  : one pass finished (1-cycle), scale_idx_out = bank written
//   error_out       : sticky watchdog flag
//   bus (master)    : engine handshake/data and shared bank bus
// ---------------------------------------------------------------------------
module blur_scale_sched
    import blur_sched_pkg::*;
#(
    parameter int BIT_DEPTH  = 8,
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 64,
    parameter int NUM_SCALES = 5,
    parameter int TIMEOUT    = 2**20,
    localparam int NB        = num_banks(NUM_SCALES),
    localparam int SW        = $clog2(NB),
    localparam int AW        = $clog2(WIDTH*HEIGHT)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          start_in,
    output logic          busy_out,
    output logic          done_out,
    output logic          scale_done_out,
    output logic [SW-1:0] scale_idx_out,
    output logic          error_out,
    blur_scale_sched_if.master bus
);

    state_t        state_q, state_d;
    logic [SW-1:0] pass_q, pass_d;
    logic [SW-1:0] scale_idx_q, scale_idx_d;
    logic          timeout_hit;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            pass_q      <= '0;
            scale_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            scale_idx_q <= scale_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        scale_idx_d = scale_idx_q;
        case (state_q)
            IDLE: begin
                // Clearing pass here also covers an octave aborted by the watchdog.
                if (start_in) begin
                    state_d = START;
                    pass_d  = '0;
                end
            end
            START: state_d = RUN;
            RUN: begin
                // A real done wins over a watchdog expiry in the same cycle.
                if (bus.blur_done_in) begin
                    state_d     = NEXT;
                    scale_idx_d = pass_q + SW'(1);
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            NEXT: begin
                if (pass_q == SW'(NUM_SCALES - 1)) begin
                    state_d = DONE;
                end else begin
                    pass_d  = pass_q + SW'(1);
                    state_d = START;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_out           = (state_q != IDLE);
    assign done_out           = (state_q == DONE);
    assign scale_done_out     = (state_q == NEXT);
    assign scale_idx_out      = scale_idx_q;
    assign bus.blur_start_out = (state_q == START);

`ifdef BLUR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          error_q, error_d;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wd_cnt_q <= '0;
            error_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == START) begin
            wd_cnt_d = '0;
        end else if (state_q == RUN) begin
            wd_cnt_d = wd_cnt_q + CW'(1);
        end
    end

    // Counter holds (cycles spent in RUN - 1), so this fires on the TIMEOUT-th RUN cycle.
    assign timeout_hit = (state_q == RUN) && (wd_cnt_q == CW'(TIMEOUT - 1));
    assign error_d     = error_q | (timeout_hit & ~bus.blur_done_in);
    assign error_out   = error_q;
`else
    // TIMEOUT only matters when the watchdog is compiled in.
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign error_out      = 1'b0;
`endif

    // Selects move only on NEXT->START, so an engine write landing with done still hits the right bank.
    logic [SW-1:0] rd_sel, wr_sel;
    logic          wr_allow;

    assign rd_sel   = pass_q;
    assign wr_sel   = pass_q + SW'(1);
    assign wr_allow = (state_q == START) || (state_q == RUN);

    assign bus.bank_rd_addr_out = bus.blur_rd_addr_in;
    assign bus.bank_wr_addr_out = bus.blur_wr_addr_in;
    assign bus.bank_wr_data_out = bus.blur_wr_pixel_in;

    bank_router #(
        .BIT_DEPTH (BIT_DEPTH),
        .NB        (NB),
        .SW        (SW)
    ) u_router (
        .rd_sel_i   (rd_sel),
        .wr_sel_i   (wr_sel),
        .wr_allow_i (wr_allow),
        .wr_valid_i (bus.blur_wr_valid_in),
        .rd_data_i  (bus.bank_rd_data_in),
        .rd_pixel_o (bus.blur_pixel_out),
        .wr_en_o    (bus.bank_wr_en_out)
    );

endmodule

// File: tb/tb_blur_scale_sched.sv
// ---------------------------------------------------------------------------
// tb_blur_scale_sched
// Directed bench for blur_scale_sched (WIDTH=HEIGHT=4, NUM_SCALES=3, 4 banks).
// The engine is modelled inline: done is raised 20 cycles after each start.
// With BLUR_TIMEOUT_EN defined, a final section checks the watchdog (TIMEOUT=50).
// ---------------------------------------------------------------------------
module tb_blur_scale_sched;

    localparam int BD  = 8;
    localparam int W   = 4;
    localparam int H   = 4;
    localparam int NS  = 3;
    localparam int TMO = 50;
    localparam int NB  = 4;
    localparam int AW  = 4;
    localparam int SW  = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, sdone, err;
    logic [SW-1:0] sidx;

    int vectors     = 0;
    int miscompares = 0;
    int n_start     = 0;
    int n_done      = 0;
    int n_sdone     = 0;

    logic [7:0] bank_v [NB];

    blur_scale_sched_if #(.BIT_DEPTH(BD), .AW(AW), .NB(NB)) bus ();

    blur_scale_sched #(
        .BIT_DEPTH  (BD),
        .WIDTH      (W),
        .HEIGHT     (H),
        .NUM_SCALES (NS),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .start_in       (start),
        .busy_out       (busy),
        .done_out       (done),
        .scale_done_out (sdone),
        .scale_idx_out  (sidx),
        .error_out      (err),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.blur_start_out) n_start++;
        if (done)               n_done++;
        if (sdone)              n_sdone++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL tb_watchdog observed=stalled expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        bank_v[0] = 8'h5A;
        bank_v[1] = 8'hA5;
        bank_v[2] = 8'h77;
        bank_v[3] = 8'h3C;
        bus.bank_rd_data_in  = {bank_v[3], bank_v[2], bank_v[1], bank_v[0]};
        bus.blur_done_in     = 1'b0;
        bus.blur_rd_addr_in  = 4'h9;
        bus.blur_wr_addr_in  = 4'h6;
        bus.blur_wr_pixel_in = 8'hC3;
        bus.blur_wr_valid_in = 1'b1;

        // Reset state, write strobe held high throughout
        repeat (3) step();
        #1;
        chk("rst_busy",   busy, 0);
        chk("rst_done",   done, 0);
        chk("rst_sdone",  sdone, 0);
        chk("rst_bstart", bus.blur_start_out, 0);
        chk("rst_err",    err, 0);
        chk("rst_sidx",   sidx, 0);
        chk("rst_wr_en",  bus.bank_wr_en_out, 4'b0000);
        chk("rd_addr_pass",  bus.bank_rd_addr_out, 4'h9);
        chk("wr_addr_pass",  bus.bank_wr_addr_out, 4'h6);
        chk("wr_data_pass",  bus.bank_wr_data_out, 8'hC3);

        step();
        rst_n = 1'b1;
        bus.blur_wr_valid_in = 1'b0;

        // Engine done while idle is ignored
        step();
        bus.blur_done_in = 1'b1;
        step();
        bus.blur_done_in = 1'b0;
        #1;
        chk("idle_done_ign_sdone", sdone, 0);
        chk("idle_done_ign_busy",  busy, 0);

        // Full octave
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk("start_latency", bus.blur_start_out, 1);
        chk("start_busy",    busy, 1);

        for (int p = 0; p < NS; p++) begin
            chk($sformatf("p%0d_rd_pix", p), bus.blur_pixel_out, bank_v[p]);
            for (int c = 0; c < 20; c++) begin
                step();
                if (p == 1 && c == 1) start = 1'b1;
                if (p == 1 && c == 2) begin
                    start = 1'b0;
                    #1;
                    chk("start_in_run_ignored", bus.blur_start_out, 0);
                    bus.blur_wr_valid_in = 1'b1;
                    #1;
                    chk("p1_route_pix",   bus.blur_pixel_out, 8'hA5);
                    chk("p1_route_wr_en", bus.bank_wr_en_out, 4'b0100);
                    bus.blur_wr_valid_in = 1'b0;
                end
            end
            bus.blur_done_in = 1'b1;
            if (p == 0) bus.blur_wr_valid_in = 1'b1;
            #1;
            if (p == 0) chk("coincident_wr_en", bus.bank_wr_en_out, 4'b0010);
            step();
            bus.blur_done_in = 1'b0;
            #1;
            chk($sformatf("p%0d_sdone", p), sdone, 1);
            chk($sformatf("p%0d_sidx", p),  sidx, p + 1);
            if (p == 0) chk("next_no_wr_en", bus.bank_wr_en_out, 4'b0000);
            bus.blur_wr_valid_in = 1'b0;
            step();
            #1;
            if (p < NS - 1) begin
                chk($sformatf("p%0d_restart", p + 1), bus.blur_start_out, 1);
            end else begin
                chk("octave_done", done, 1);
                chk("done_busy",   busy, 1);
            end
        end
        step();
        #1;
        chk("after_done", done, 0);
        chk("after_busy", busy, 0);
        chk("n_blur_start", n_start, 3);
        chk("n_done",       n_done, 1);
        chk("n_scale_done", n_sdone, 3);

        // Reset mid pass 1
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        bus.blur_done_in = 1'b1;
        step();
        bus.blur_done_in = 1'b0;
        step();
        step();
        bus.blur_wr_valid_in = 1'b1;
        #1;
        chk("mid_p1_pix",   bus.blur_pixel_out, 8'hA5);
        chk("mid_p1_wr_en", bus.bank_wr_en_out, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy",  busy, 0);
        chk("async_rst_wr_en", bus.bank_wr_en_out, 4'b0000);
        chk("async_rst_sidx",  sidx, 0);
        step();
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk("restart_bstart", bus.blur_start_out, 1);
        chk("restart_pix",    bus.blur_pixel_out, 8'h5A);
        chk("restart_wr_en",  bus.bank_wr_en_out, 4'b0010);
        bus.blur_wr_valid_in = 1'b0;

`ifdef BLUR_TIMEOUT_EN
        // Engine never answers: 50 RUN cycles then abort
        for (int c = 0; c < TMO; c++) step();
        #1;
        chk("tmo_not_yet_err",  err, 0);
        chk("tmo_not_yet_busy", busy, 1);
        step();
        #1;
        chk("tmo_err",  err, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_no_done", n_done, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk("tmo_restart", bus.blur_start_out, 1);
        chk("tmo_err_sticky", err, 1);
`else
        repeat (5) step();
        #1;
        chk("no_wd_err",  err, 0);
        chk("no_wd_busy", busy, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
